// File: rtl/cpu_clock_controller.sv
// cpu_clock_controller
//
// Purpose: generates the registered CPU bus clock from the 100MHz system clock.
// A power-of-two divider sets the half-period (selectable at run time), the
// clock can free-run or be single-stepped from a debounced push button, and a
// halt request stops the bus clock cleanly at a low phase. One-cycle strobes
// mark each bus_clk edge for logic that runs on clock enables.
//
// Optional feature: define CYCLE_COUNTER_EN to build the bus-cycle counter.
// Without it cycle_count is tied to zero.
//
// Ports:
//   clk           in   system clock, 100MHz
//   rst_n         in   asynchronous active-low reset
//   hlt           in   halt request from the CPU control logic
//   run_mode      in   1 = free-run, 0 = single-step
//   step_btn      in   raw, asynchronous, active-high step button
//   speed_sel     in   half-period = 2^(DIV_WIDTH-1-speed_sel) clk, minimum 1
//   bus_clk       out  registered CPU clock level
//   bus_tick      out  one-cycle strobe on the cycle bus_clk rises
//   control_tick  out  one-cycle strobe on the cycle bus_clk falls
//   halted        out  high while the controller is halted
//   cycle_count   out  completed bus_clk rising edges (0 when feature off)

module cpu_clock_controller #(
    parameter int DIV_WIDTH     = 26,
    parameter int SEL_WIDTH     = 3,
    parameter int DEBOUNCE_BITS = 20,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hlt,
    input  logic                 run_mode,
    input  logic                 step_btn,
    input  logic [SEL_WIDTH-1:0] speed_sel,
    output logic                 bus_clk,
    output logic                 bus_tick,
    output logic                 control_tick,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    // state      | meaning
    // S_LOW      | bus_clk low, counting the low half-period
    // S_HIGH     | bus_clk high, free-running half-period
    // S_STEP_WAIT| bus_clk low, divider idle, waiting for a step press
    // S_STEP_HIGH| bus_clk high for one half-period after a step press
    // S_HALTED   | bus_clk low, halted flag set, divider idle
    typedef enum logic [2:0] {
        S_LOW,
        S_HIGH,
        S_STEP_WAIT,
        S_STEP_HIGH,
        S_HALTED
    } state_t;

    localparam int MAX_SHIFT = DIV_WIDTH - 1;

    state_t                   state;
    logic [DIV_WIDTH-1:0]     div_cnt;
    logic [DIV_WIDTH-1:0]     half_m1;
    logic                     phase_end;

    logic [1:0]               sync_q;
    logic                     db_state;
    logic [DEBOUNCE_BITS-1:0] db_cnt;
    logic                     step_pulse;

    // Terminal count for the divider. Selections past the divider width clamp
    // to a half-period of one clk.
    always_comb begin
        if (32'(speed_sel) >= MAX_SHIFT) begin
            half_m1 = '0;
        end else begin
            half_m1 = (DIV_WIDTH'(1) << (MAX_SHIFT - 32'(speed_sel))) - DIV_WIDTH'(1);
        end
    end

    // >= rather than == so a switch to a faster speed mid-phase ends the
    // phase on the next cycle instead of running the counter round to wrap.
    assign phase_end = (div_cnt >= half_m1);

    // Step button: two-flop synchroniser, then the input must differ from the
    // accepted level for 2^DEBOUNCE_BITS consecutive cycles before it is taken.
    // Only an accepted 0->1 change produces a step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            db_state   <= 1'b0;
            db_cnt     <= '0;
            step_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], step_btn};
            step_pulse <= 1'b0;
            if (sync_q[1] == db_state) begin
                db_cnt <= '0;
            end else if (db_cnt == '1) begin
                db_cnt     <= '0;
                db_state   <= sync_q[1];
                step_pulse <= sync_q[1];
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // All outputs are registered together with the state so bus_clk cannot
    // glitch and the strobes line up exactly with the bus_clk edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_LOW;
            div_cnt      <= '0;
            bus_clk      <= 1'b0;
            bus_tick     <= 1'b0;
            control_tick <= 1'b0;
            halted       <= 1'b0;
        end else begin
            bus_tick     <= 1'b0;
            control_tick <= 1'b0;
            case (state)
                S_LOW: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        if (hlt) begin
                            state  <= S_HALTED;
                            halted <= 1'b1;
                        end else if (!run_mode) begin
                            state <= S_STEP_WAIT;
                        end else begin
                            state    <= S_HIGH;
                            bus_clk  <= 1'b1;
                            bus_tick <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                // hlt is not looked at while high: the high phase always runs
                // to completion so the CPU never sees a runt pulse.
                S_HIGH, S_STEP_HIGH: begin
                    if (phase_end) begin
                        div_cnt      <= '0;
                        state        <= S_LOW;
                        bus_clk      <= 1'b0;
                        control_tick <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_STEP_WAIT: begin
                    div_cnt <= '0;
                    if (hlt) begin
                        state  <= S_HALTED;
                        halted <= 1'b1;
                    end else if (step_pulse) begin
                        state    <= S_STEP_HIGH;
                        bus_clk  <= 1'b1;
                        bus_tick <= 1'b1;
                    end else if (run_mode) begin
                        state    <= S_HIGH;
                        bus_clk  <= 1'b1;
                        bus_tick <= 1'b1;
                    end
                end
                S_HALTED: begin
                    div_cnt <= '0;
                    if (!hlt && (run_mode || step_pulse)) begin
                        state    <= S_HIGH;
                        halted   <= 1'b0;
                        bus_clk  <= 1'b1;
                        bus_tick <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_LOW;
                    div_cnt <= '0;
                    bus_clk <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CYCLE_COUNTER_EN
    // Counts bus_tick strobes; wraps naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
        end else if (bus_tick && !halted) begin
            cycle_count <= cycle_count + 1'b1;
        end
    end
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_cpu_clock_controller.sv
module tb_cpu_clock_controller;

    localparam int TB_DIV = 4;
    localparam int TB_CNT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hlt;
    logic       run_mode;
    logic       step_btn;
    logic [2:0] speed_sel;
    logic       bus_clk;
    logic       bus_tick;
    logic       control_tick;
    logic       halted;
    logic [TB_CNT-1:0] cycle_count;

    cpu_clock_controller #(
        .DIV_WIDTH    (TB_DIV),
        .SEL_WIDTH    (3),
        .DEBOUNCE_BITS(3),
        .CNT_WIDTH    (TB_CNT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hlt         (hlt),
        .run_mode    (run_mode),
        .step_btn    (step_btn),
        .speed_sel   (speed_sel),
        .bus_clk     (bus_clk),
        .bus_tick    (bus_tick),
        .control_tick(control_tick),
        .halted      (halted),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: half-period in clk cycles for a given selection.
    function automatic int half_of(input int s);
        return (s >= TB_DIV - 1) ? 1 : (1 << (TB_DIV - 1 - s));
    endfunction

    // Continuous edge/strobe monitor, sampled on the falling clk edge.
    logic       prev_clk = 1'b0;
    int         hi_run   = 0;
    bit         chk_runs = 1'b0;
    int         exp_half = 8;
    logic [TB_CNT-1:0] exp_cc = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_clk = 1'b0;
            hi_run   = 0;
            exp_cc   = '0;
        end else begin
            check("bus_tick_edge", bus_tick, bus_clk & ~prev_clk);
            check("control_tick_edge", control_tick, ~bus_clk & prev_clk);
`ifdef CYCLE_COUNTER_EN
            check("cycle_count", cycle_count, exp_cc);
            if (bus_tick) exp_cc = exp_cc + 1'b1;
`else
            check("cycle_count_zero", cycle_count, 0);
`endif
            if (bus_clk) begin
                hi_run++;
            end else if (prev_clk) begin
                if (chk_runs) check("high_run_len", hi_run, exp_half);
                hi_run = 0;
            end
            prev_clk = bus_clk;
        end
    end

    task automatic wait_tick(input bit rise, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rise ? bus_tick : control_tick) && n < budget);
        check(rise ? "bus_tick_seen" : "control_tick_seen",
              rise ? bus_tick : control_tick, 1);
    endtask

    task automatic run_len(input logic level, input int budget, output int n);
        n = 0;
        while (bus_clk == level && n < budget) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic press(input int bounce);
        for (int i = 0; i < bounce; i++) begin
            step_btn = ~i[0];
            @(negedge clk);
        end
        step_btn = 1'b1;
        repeat (12) @(negedge clk);
        step_btn = 1'b0;
    endtask

    task automatic watch(input int cycles, output int ticks, output int ctls, output int hi);
        ticks = 0;
        ctls  = 0;
        hi    = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus_tick) ticks++;
            if (control_tick) ctls++;
            if (bus_clk) hi++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2, s, viol, t, c, h;
        rst_n = 1'b0; hlt = 1'b0; run_mode = 1'b1; step_btn = 1'b0; speed_sel = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_bus_clk", bus_clk, 0);
        check("rst_bus_tick", bus_tick, 0);
        check("rst_control_tick", control_tick, 0);
        check("rst_halted", halted, 0);
        check("rst_cycle_count", cycle_count, 0);
        #1 rst_n = 1'b1;

        // Free run at the slowest setting: 8 low, 8 high.
        wait_tick(1'b1, 40, n);
        check("first_rise_delay", n, 8);
        run_len(1'b1, 40, n);  check("free_high_len", n, 8);
        run_len(1'b0, 40, n);  check("free_low_len", n, 8);
        run_len(1'b1, 40, n);  check("free_high_len2", n, 8);

        // Speed change mid-low with div_cnt = 5 ends the phase next cycle.
        wait_tick(1'b0, 40, n);
        repeat (5) @(negedge clk);
        speed_sel = 3'd2;
        @(negedge clk);
        check("speed_switch_tick", bus_tick, 1);
        run_len(1'b1, 40, n);  check("fast_high_len", n, 2);
        run_len(1'b0, 40, n);  check("fast_low_len", n, 2);

        // Random speeds, including selections past the clamp point.
        for (int it = 0; it < 12; it++) begin
            s = int'($urandom_range(0, 7));
            speed_sel = s[2:0];
            wait_tick(1'b1, 40, n);
            wait_tick(1'b1, 40, n);
            run_len(1'b1, 40, n);  check("rnd_high_len", n, half_of(s));
            run_len(1'b0, 40, n);  check("rnd_low_len", n, half_of(s));
        end

        // Halt requested two cycles into a high phase.
        speed_sel = 3'd0;
        wait_tick(1'b1, 40, n);
        wait_tick(1'b1, 40, n);
        n = 0;
        while (bus_clk && n < 40) begin
            n++;
            if (n == 2) hlt = 1'b1;
            @(negedge clk);
        end
        check("halt_high_len", n, 8);
        n = 0;
        while (!halted && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("halt_low_len", n, 8);
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus_clk || !halted || bus_tick) viol++;
        end
        check("halt_hold_violations", viol, 0);

        // Dropping hlt alone in step mode must not leave HALTED.
        run_mode = 1'b0;
        hlt = 1'b0;
        watch(20, t, c, h);
        check("halt_stepmode_ticks", t, 0);
        check("halt_stepmode_halted", halted, 1);
        run_mode = 1'b1;
        @(negedge clk);
        check("unhalt_tick", bus_tick, 1);
        check("unhalt_halted", halted, 0);
        run_len(1'b1, 40, n);  check("unhalt_high_len", n, 8);

        // Random halt requests: every high phase must run full length.
        exp_half = 8;
        chk_runs = 1'b1;
        for (int it = 0; it < 8; it++) begin
            hlt = 1'b1;
            n = 0;
            while (!halted && n < 60) begin
                @(negedge clk);
                n++;
            end
            check("rnd_halted", halted, 1);
            s = int'($urandom_range(0, 3));
            speed_sel = s[2:0];
            exp_half  = half_of(s);
            repeat ($urandom_range(1, 10)) @(negedge clk);
            check("rnd_halt_bus_clk", bus_clk, 0);
            hlt = 1'b0;
            @(negedge clk);
            check("rnd_resume_tick", bus_tick, 1);
            repeat ($urandom_range(5, 40)) @(negedge clk);
        end
        chk_runs = 1'b0;

        // Single-step: bouncing press gives one full high pulse.
        speed_sel = 3'd0;
        run_mode  = 1'b0;
        repeat (40) @(negedge clk);
        watch(20, t, c, h);
        check("stepwait_idle_ticks", t, 0);
        check("stepwait_idle_high", h, 0);
        fork
            press(3);
            watch(80, t, c, h);
        join
        check("step_bus_ticks", t, 1);
        check("step_control_ticks", c, 1);
        check("step_high_len", h, 8);

        // Now in STEP_WAIT, so hlt is taken on the very next clock.
        hlt = 1'b1;
        @(negedge clk);
        check("stepwait_hlt_halted", halted, 1);
        hlt = 1'b0;
        repeat (5) @(negedge clk);
        check("halted_no_step_yet", halted, 1);
        fork
            press(0);
            begin
                wait_tick(1'b1, 60, n);
                run_len(1'b1, 40, n2);
                check("step_from_halt_high", n2, 8);
            end
        join
        check("step_from_halt_cleared", halted, 0);

        // Reset in the middle of a high phase.
        run_mode = 1'b1;
        repeat (30) @(negedge clk);
        wait_tick(1'b1, 40, n);
        repeat (3) @(negedge clk);
        check("pre_reset_high", bus_clk, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_bus_clk", bus_clk, 0);
        check("async_rst_bus_tick", bus_tick, 0);
        check("async_rst_control_tick", control_tick, 0);
        check("async_rst_halted", halted, 0);
        check("async_rst_cycle_count", cycle_count, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        wait_tick(1'b1, 40, n);
        check("post_reset_rise_delay", n, 8);

        // Long free run to carry the counter past its wrap point.
        speed_sel = 3'd3;
        repeat (60) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
